conv_stream_feeder: RTL



---
 rtl/conv_stream_feeder.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/conv_stream_feeder.sv
// conv_stream_feeder: streams filter coefficients and image bands from a
// pixel RAM into the accelerator input FIFO. Macro CONV_FEED_RD_EN adds RDQ.
module conv_stream_feeder #(
    parameter int BIT_LENGTH  = 16,
    parameter int KERNEL_SIZE = 3,
    parameter int DIM_W       = 8,
    parameter int ADDR_W      = 16,
    parameter int IMG_BASE    = 16
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  start,
    input  logic [DIM_W-1:0]      img_w,
    input  logic [DIM_W-1:0]      img_h,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_rd_en,
    input  logic [BIT_LENGTH-1:0] mem_rdata,
    input  logic                  full_in,
    output logic [BIT_LENGTH-1:0] dout,
    output logic                  dout_wr,
    output logic                  newline,
    output logic                  rd_req,
    output logic                  busy,
    output logic                  done,
    output logic                  param_err
);
    localparam int PW = 2 * DIM_W + 1;
    localparam logic [DIM_W-1:0] KD  = DIM_W'(KERNEL_SIZE);
    localparam logic [DIM_W-1:0] KM1 = DIM_W'(KERNEL_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        FETCH,
        EMIT,
        NL,
`ifdef CONV_FEED_RD_EN
        RDQ,
`endif
        FIN
    } state_t;

    state_t                state_q, state_d;
    logic [DIM_W-1:0]      w_q, w_d;
    logic [DIM_W-1:0]      h_q, h_d;
    logic [DIM_W-1:0]      x_q, x_d;
    logic [DIM_W-1:0]      j_q, j_d;
    logic [DIM_W-1:0]      y_q, y_d;
    logic                  coef_q, coef_d;
    logic                  fresh_q, fresh_d;
    logic                  perr_q, perr_d;
    logic [BIT_LENGTH-1:0] hold_q, hold_d;

    logic [DIM_W:0]        row_sum;
    logic [PW-1:0]         row_off;
    logic [ADDR_W-1:0]     coef_addr;
    logic [ADDR_W-1:0]     band_addr;
    logic [DIM_W-1:0]      x_last;

    assign param_err = perr_q;

    // Read addresses for the coefficient and image-band phases
    always_comb begin
        row_sum   = {1'b0, y_q} + {1'b0, j_q};
        row_off   = PW'(row_sum) * PW'(w_q);
        coef_addr = ADDR_W'(j_q) * ADDR_W'(KERNEL_SIZE) + ADDR_W'(x_q);
        band_addr = ADDR_W'(IMG_BASE) + ADDR_W'(row_off) + ADDR_W'(x_q);
        x_last    = coef_q ? KM1 : w_q - 1'b1;
    end

`ifndef CONV_FEED_RD_EN
    assign rd_req = 1'b0;
`endif

    // Next-state, counter advance and output strobes
    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        h_d       = h_q;
        x_d       = x_q;
        j_d       = j_q;
        y_d       = y_q;
        coef_d    = coef_q;
        perr_d    = perr_q;
        hold_d    = hold_q;
        fresh_d   = 1'b0;
        mem_addr  = '0;
        mem_rd_en = 1'b0;
        dout_wr   = 1'b0;
        newline   = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
`ifdef CONV_FEED_RD_EN
        rd_req    = 1'b0;
`endif
        // a fresh word comes straight from RAM; a stalled one from hold_q
        dout      = fresh_q ? mem_rdata : hold_q;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_d     = img_w;
                    h_d     = img_h;
                    perr_d  = 1'b0;
                    x_d     = '0;
                    j_d     = '0;
                    y_d     = '0;
                    coef_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (w_q < KD || h_q < KD) begin
                    perr_d  = 1'b1;
                    state_d = FIN;
                end else begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                mem_rd_en = 1'b1;
                mem_addr  = coef_q ? coef_addr : band_addr;
                fresh_d   = 1'b1;
                state_d   = EMIT;
            end
            EMIT: begin
                if (fresh_q) hold_d = mem_rdata;
                if (!full_in) begin
                    dout_wr = 1'b1;
                    state_d = FETCH;
                    if (j_q == KM1) begin
                        j_d = '0;
                        if (x_q == x_last) begin
                            x_d = '0;
                            if (coef_q) coef_d = 1'b0;
                            else        state_d = NL;
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            NL: begin
                if (!full_in) begin
                    newline = 1'b1;
                    if (y_q == h_q - KD) begin
`ifdef CONV_FEED_RD_EN
                        state_d = RDQ;
`else
                        state_d = FIN;
`endif
                    end else begin
                        y_d     = y_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
`ifdef CONV_FEED_RD_EN
            RDQ: begin
                if (!full_in) begin
                    rd_req  = 1'b1;
                    state_d = FIN;
                end
            end
`endif
            FIN: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            w_q     <= '0;
            h_q     <= '0;
            x_q     <= '0;
            j_q     <= '0;
            y_q     <= '0;
            coef_q  <= 1'b0;
            fresh_q <= 1'b0;
            perr_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            h_q     <= h_d;
            x_q     <= x_d;
            j_q     <= j_d;
            y_q     <= y_d;
            coef_q  <= coef_d;
            fresh_q <= fresh_d;
            perr_q  <= perr_d;
            hold_q  <= hold_d;
        end
    end
endmodule
